// File: rtl/shift_frame_pkg.sv
// -----------------------------------------------------------------------------
// shift_frame_pkg
// Shared definitions for the shift_frame serialiser/deserialiser.
//   state_t        : frame FSM states (IDLE, SHIFT, DONE)
//   DIR_LSB_FIRST  : direction-latch encoding for LSB-first shifting
//   DIR_MSB_FIRST  : direction-latch encoding for MSB-first shifting
// -----------------------------------------------------------------------------
package shift_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic DIR_LSB_FIRST = 1'b1;
   localparam logic DIR_MSB_FIRST = 1'b0;

endpackage : shift_frame_pkg

// File: rtl/shift_frame.sv
// -----------------------------------------------------------------------------
// shift_frame
// Loads a parallel word, shifts it out serially over exactly WIDTH cycles while
// shifting serial_in into the vacated end, then presents the received word
// with a valid/ready handshake.
//
// Parameters
//   WIDTH         : frame length in bits (>= 2)
//   LSB_FIRST_DEF : direction used when lsb_first_en is low (1 = LSB first)
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   load_valid    : parallel word offered      load_ready : word accepted
//   load_data     : word to serialise
//   lsb_first_en  : use lsb_first instead of LSB_FIRST_DEF at load
//   lsb_first     : frame direction (1 = LSB first)
//   serial_in     : receive bit                serial_out : transmit bit
//   busy          : frame shift in progress
//   cap_valid     : captured word available    cap_data   : captured word
//   cap_ready     : consumer takes captured word
// -----------------------------------------------------------------------------
module shift_frame
   import shift_frame_pkg::*;
#(
   parameter int   WIDTH         = 8,
   parameter logic LSB_FIRST_DEF = DIR_LSB_FIRST
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             lsb_first_en,
   input  logic             lsb_first,
   input  logic             serial_in,
   output logic             serial_out,
   output logic             busy,
   output logic             cap_valid,
   output logic [WIDTH-1:0] cap_data,
   input  logic             cap_ready
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [WIDTH-1:0]  r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_lsb_first;
   logic              w_load;

   // A load is only taken in IDLE; load_valid elsewhere is simply ignored.
   assign w_load = (r_state == ST_IDLE) && load_valid;

   // NOTE: every signal driven in always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (load_valid)          w_next_state = ST_SHIFT;
         ST_SHIFT: if (r_cnt == CNT_LAST)   w_next_state = ST_DONE;
         // A load offered alongside cap_ready is not taken here; IDLE accepts
         // it on the following cycle at the earliest.
         ST_DONE:  if (cap_ready)           w_next_state = ST_IDLE;
         default:                           w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_lsb_first <= LSB_FIRST_DEF;
      end else begin
         r_state <= w_next_state;
         if (w_load) begin
            r_shift     <= load_data;
            r_cnt       <= '0;
            r_lsb_first <= lsb_first_en ? lsb_first : LSB_FIRST_DEF;
         end else if (r_state == ST_SHIFT) begin
            r_cnt <= r_cnt + CNT_W'(1);
            // Transmit end leaves, receive bit enters at the opposite end.
            if (r_lsb_first == DIR_LSB_FIRST)
               r_shift <= {serial_in, r_shift[WIDTH-1:1]};
            else
               r_shift <= {r_shift[WIDTH-2:0], serial_in};
         end
      end
   end

   assign load_ready = (r_state == ST_IDLE);
   assign busy       = (r_state == ST_SHIFT);
   assign serial_out = busy ? ((r_lsb_first == DIR_LSB_FIRST) ? r_shift[0]
                                                              : r_shift[WIDTH-1])
                            : 1'b0;
   assign cap_valid  = (r_state == ST_DONE);
   assign cap_data   = cap_valid ? r_shift : '0;

endmodule : shift_frame

// File: tb/tb_shift_frame.sv
// -----------------------------------------------------------------------------
// tb_shift_frame
// Directed bench for shift_frame. An 8-bit instance (LSB first by default)
// covers the main frame scenarios; a 2-bit MSB-first-by-default instance
// covers the minimum frame length. Expected serial bits and captured words are
// computed by a reference model when a frame is launched and popped from
// queues as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_shift_frame;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- 8-bit instance ----------------
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_data  = '0;
   logic       lsb_first_en = 1'b0;
   logic       lsb_first  = 1'b0;
   logic       serial_in;
   logic       serial_out;
   logic       busy;
   logic       cap_valid;
   logic [7:0] cap_data;
   logic       cap_ready  = 1'b0;
   logic       loop_en    = 1'b0;
   logic       sin_c      = 1'b0;

   assign serial_in = loop_en ? serial_out : sin_c;

   shift_frame #(.WIDTH(8), .LSB_FIRST_DEF(1'b1)) u_dut8 (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .lsb_first_en (lsb_first_en),
      .lsb_first    (lsb_first),
      .serial_in    (serial_in),
      .serial_out   (serial_out),
      .busy         (busy),
      .cap_valid    (cap_valid),
      .cap_data     (cap_data),
      .cap_ready    (cap_ready)
   );

   // ---------------- 2-bit instance ----------------
   logic       ld2_valid = 1'b0;
   logic       ld2_ready;
   logic [1:0] ld2_data  = '0;
   logic       sin2      = 1'b0;
   logic       sout2;
   logic       busy2;
   logic       cv2;
   logic [1:0] cd2;
   logic       cr2       = 1'b0;

   shift_frame #(.WIDTH(2), .LSB_FIRST_DEF(1'b0)) u_dut2 (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (ld2_valid),
      .load_ready   (ld2_ready),
      .load_data    (ld2_data),
      .lsb_first_en (1'b0),
      .lsb_first    (1'b1),
      .serial_in    (sin2),
      .serial_out   (sout2),
      .busy         (busy2),
      .cap_valid    (cv2),
      .cap_data     (cd2),
      .cap_ready    (cr2)
   );

   // ---------------- scoreboard ----------------
   logic       exp_bits[$];
   logic [7:0] exp_words[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode: 0 = serial_in held 0, 1 = held 1, 2 = serial_out looped back
   task automatic model_frame(input logic [7:0] data, input logic lsb_dir, input int mode);
      logic [7:0] sr;
      logic       b;
      logic       s;
      sr = data;
      for (int i = 0; i < 8; i++) begin
         b = lsb_dir ? sr[0] : sr[7];
         exp_bits.push_back(b);
         s = (mode == 2) ? b : (mode == 1);
         sr = lsb_dir ? {s, sr[7:1]} : {sr[6:0], s};
      end
      exp_words.push_back(sr);
   endtask

   // Called at a falling edge in IDLE; returns at the falling edge after the
   // load edge, with the first serial bit on serial_out.
   task automatic start_frame(input logic [7:0] data, input logic en, input logic dir_in,
                              input int mode);
      loop_en      = (mode == 2);
      sin_c        = (mode == 1);
      model_frame(data, en ? dir_in : 1'b1, mode);
      check("idle_load_ready", load_ready, 1);
      load_valid   = 1'b1;
      load_data    = data;
      lsb_first_en = en;
      lsb_first    = dir_in;
      @(negedge clk);
      load_valid   = 1'b0;
      lsb_first_en = ~en;    // direction must stay latched from the load
      lsb_first    = ~dir_in;
   endtask

   // WIDTH shift cycles, then the DONE state with the captured word.
   task automatic shift_and_capture(input string tag);
      logic       eb;
      logic [7:0] ew;
      for (int i = 0; i < 8; i++) begin
         check({tag, "_sb_bits"}, (exp_bits.size() != 0), 1);
         eb = (exp_bits.size() != 0) ? exp_bits.pop_front() : 1'b0;
         check({tag, "_busy"}, busy, 1);
         check({tag, "_ld_rdy"}, load_ready, 0);
         check({tag, "_sout"}, serial_out, eb);
         check({tag, "_cv_early"}, cap_valid, 0);
         @(negedge clk);
      end
      check({tag, "_sb_words"}, (exp_words.size() != 0), 1);
      ew = (exp_words.size() != 0) ? exp_words.pop_front() : 8'h00;
      check({tag, "_cap_valid"}, cap_valid, 1);
      check({tag, "_cap_data"}, cap_data, ew);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_sout_done"}, serial_out, 0);
   endtask

   task automatic release_capture(input string tag);
      cap_ready = 1'b1;
      @(negedge clk);
      cap_ready = 1'b0;
      check({tag, "_rel_cv"}, cap_valid, 0);
      check({tag, "_rel_cd"}, cap_data, 0);
      check({tag, "_rel_lr"}, load_ready, 1);
   endtask

   logic [7:0] held;

   initial begin
      // ---- reset ----
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_load_ready", load_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_sout", serial_out, 0);
      check("rst_cap_valid", cap_valid, 0);
      check("rst_cap_data", cap_data, 0);

      // ---- cap_ready in IDLE has no effect ----
      cap_ready = 1'b1;
      @(negedge clk);
      cap_ready = 1'b0;
      check("idle_cr_lr", load_ready, 1);
      check("idle_cr_cv", cap_valid, 0);

      // ---- LSB first (default), loopback, 0xA5 ----
      start_frame(8'hA5, 1'b0, 1'b0, 2);
      shift_and_capture("lsb_loop");
      check("lsb_loop_const", cap_data, 8'hA5);
      release_capture("lsb_loop");

      // ---- MSB first, serial_in held 1, 0x3C ----
      start_frame(8'h3C, 1'b1, 1'b0, 1);
      shift_and_capture("msb_ones");
      check("msb_ones_const", cap_data, 8'hFF);
      release_capture("msb_ones");

      // ---- DONE held 20 cycles, load_valid ignored ----
      start_frame(8'h5A, 1'b1, 1'b1, 0);
      shift_and_capture("hold");
      held = cap_data;
      for (int i = 0; i < 20; i++) begin
         load_valid = 1'b1;
         load_data  = 8'(i * 37);
         @(negedge clk);
         check("hold_cv", cap_valid, 1);
         check("hold_cd", cap_data, held);
         check("hold_lr", load_ready, 0);
         check("hold_busy", busy, 0);
      end
      load_valid = 1'b0;
      release_capture("hold");
      check("hold_no_queued", busy, 0);

      // ---- cap_ready and load_valid together in DONE ----
      start_frame(8'h96, 1'b1, 1'b0, 0);
      shift_and_capture("both");
      model_frame(8'hC3, 1'b1, 0);
      cap_ready    = 1'b1;
      load_valid   = 1'b1;
      load_data    = 8'hC3;
      lsb_first_en = 1'b1;
      lsb_first    = 1'b1;
      sin_c        = 1'b0;
      loop_en      = 1'b0;
      @(negedge clk);
      cap_ready = 1'b0;
      check("both_idle_lr", load_ready, 1);
      check("both_idle_busy", busy, 0);
      check("both_idle_cv", cap_valid, 0);
      @(negedge clk);
      load_valid = 1'b0;
      shift_and_capture("both_next");
      release_capture("both_next");

      // ---- reset at shift cycle 4 ----
      start_frame(8'h77, 1'b1, 1'b0, 1);
      for (int i = 0; i < 4; i++) begin
         check("abort_sout", serial_out, exp_bits.pop_front());
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_sout0", serial_out, 0);
      check("abort_cv", cap_valid, 0);
      check("abort_cd", cap_data, 0);
      check("abort_lr", load_ready, 1);
      exp_bits.delete();
      exp_words.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("abort_no_cv", cap_valid, 0);
      end
      start_frame(8'h0F, 1'b0, 1'b0, 0);
      shift_and_capture("post_rst");
      check("post_rst_const", cap_data, 8'h00);
      release_capture("post_rst");

      // ---- WIDTH=2, MSB-first default, load 2'b10, serial_in 1 ----
      sin2      = 1'b1;
      check("w2_lr", ld2_ready, 1);
      ld2_valid = 1'b1;
      ld2_data  = 2'b10;
      @(negedge clk);
      ld2_valid = 1'b0;
      check("w2_busy", busy2, 1);
      check("w2_bit0", sout2, 1);
      check("w2_cv0", cv2, 0);
      @(negedge clk);
      check("w2_bit1", sout2, 0);
      check("w2_cv1", cv2, 0);
      @(negedge clk);
      check("w2_cv", cv2, 1);
      check("w2_cd", cd2, 2'b11);
      check("w2_busy_done", busy2, 0);
      cr2 = 1'b1;
      @(negedge clk);
      cr2 = 1'b0;
      check("w2_rel_cv", cv2, 0);
      check("w2_rel_cd", cd2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_shift_frame
